// File: rtl/radix_converter.sv
// radix_converter: sequential number-to-digits converter with a run-time base.
// One restoring shift-subtract divider produces one quotient bit per cycle;
// each digit costs BIT_DEPTH divide cycles plus one STORE cycle.
// Optional feature macro: RADIX_SIGNED_EN (two's-complement input, magnitude
// conversion plus a negative flag). Without it the input is unsigned.
//
// Handshake: a request transfers on a rising clk edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. Once raised,
// out_valid and all result outputs stay stable until that transfer.
module radix_converter #(
    parameter int BIT_DEPTH   = 16,
    parameter int NUM_DIGITS  = 5,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BIT_DEPTH-1:0]              number,
    input  logic [DIGIT_WIDTH:0]              base,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_DIGITS*DIGIT_WIDTH-1:0] digits,
    output logic [NUM_DIGITS-1:0]             blank,
    output logic                              overflow,
    output logic                              error,
    output logic                              negative
);

    localparam int CW = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0]          CNT_LAST = CW'(BIT_DEPTH - 1);
    localparam logic [IW-1:0]          IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [DIGIT_WIDTH:0]   BASE_MIN = 2;
    localparam logic [DIGIT_WIDTH:0]   BASE_MAX = {1'b1, {DIGIT_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_STORE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                              state_q, state_d;
    logic [BIT_DEPTH-1:0]                work_q, work_d;      // dividend, becomes quotient
    logic [DIGIT_WIDTH:0]                rem_q, rem_d;
    logic [DIGIT_WIDTH:0]                base_q, base_d;
    logic                                bad_q, bad_d;        // latched illegal-base flag
    logic [CW-1:0]                       bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]                       idx_q, idx_d;
    logic [NUM_DIGITS*DIGIT_WIDTH-1:0]   wdig_q, wdig_d;      // digits of the request in flight
    logic [NUM_DIGITS*DIGIT_WIDTH-1:0]   digits_q, digits_d;
    logic [NUM_DIGITS-1:0]               blank_q, blank_d;
    logic                                overflow_q, overflow_d;
    logic                                error_q, error_d;
    logic                                out_valid_q, out_valid_d;

    logic [BIT_DEPTH-1:0]                magnitude;
    logic [DIGIT_WIDTH+1:0]              rem_sh;
    logic                                q_bit;
    logic [NUM_DIGITS-1:0]               blank_calc;
    logic                                hi_zero;
    logic                                accept;
    logic                                load_out;

    assign accept   = (state_q == S_IDLE) && in_valid;
    assign load_out = (state_q == S_DONE) && !out_valid_q;

`ifdef RADIX_SIGNED_EN
    logic neg_in_q, neg_in_d;
    logic negative_q, negative_d;

    // Magnitude of the two's-complement input; the most-negative value maps to 2^(BIT_DEPTH-1).
    assign magnitude = number[BIT_DEPTH-1] ? ((~number) + BIT_DEPTH'(1)) : number;

    // Sign is latched on accept and published with the other results (cleared on error).
    always_comb begin
        neg_in_d   = neg_in_q;
        negative_d = negative_q;
        if (accept)   neg_in_d   = number[BIT_DEPTH-1];
        if (load_out) negative_d = neg_in_q && !bad_q;
    end

    // Sign registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_in_q   <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            neg_in_q   <= neg_in_d;
            negative_q <= negative_d;
        end
    end

    assign negative = negative_q;
`else
    assign magnitude = number;
    assign negative  = 1'b0;
`endif

    // One restoring-division step: shift in the next dividend bit, subtract base if it fits.
    assign rem_sh = {rem_q, work_q[BIT_DEPTH-1]};
    assign q_bit  = (rem_sh >= {1'b0, base_q});

    // Leading-zero mask: digit i is blank when it and every higher digit are zero; digit 0 never is.
    always_comb begin
        blank_calc = '0;
        hi_zero    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            hi_zero       = hi_zero && (wdig_q[i*DIGIT_WIDTH +: DIGIT_WIDTH] == '0);
            blank_calc[i] = hi_zero;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        rem_d       = rem_q;
        base_d      = base_q;
        bad_d       = bad_q;
        bit_cnt_d   = bit_cnt_q;
        idx_d       = idx_q;
        wdig_d      = wdig_q;
        digits_d    = digits_q;
        blank_d     = blank_q;
        overflow_d  = overflow_q;
        error_d     = error_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d    = magnitude;
                    base_d    = base;
                    rem_d     = '0;
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    bad_d     = (base < BASE_MIN) || (base > BASE_MAX);
                    state_d   = bad_d ? S_DONE : S_DIV;
                end
            end
            S_DIV: begin
                work_d    = {work_q[BIT_DEPTH-2:0], q_bit};
                rem_d     = q_bit ? (rem_sh[DIGIT_WIDTH:0] - base_q) : rem_sh[DIGIT_WIDTH:0];
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_LAST) state_d = S_STORE;
            end
            S_STORE: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx_q == IW'(i)) wdig_d[i*DIGIT_WIDTH +: DIGIT_WIDTH] = rem_q[DIGIT_WIDTH-1:0];
                end
                rem_d     = '0;
                bit_cnt_d = '0;
                idx_d     = idx_q + 1'b1;
                state_d   = (idx_q == IDX_LAST) ? S_DONE : S_DIV;
            end
            S_DONE: begin
                // First DONE cycle publishes results; later cycles wait for the consumer.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    digits_d    = bad_q ? '0 : wdig_q;
                    blank_d     = bad_q ? '0 : blank_calc;
                    overflow_d  = !bad_q && (work_q != '0);
                    error_d     = bad_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            rem_q       <= '0;
            base_q      <= '0;
            bad_q       <= 1'b0;
            bit_cnt_q   <= '0;
            idx_q       <= '0;
            wdig_q      <= '0;
            digits_q    <= '0;
            blank_q     <= '0;
            overflow_q  <= 1'b0;
            error_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            base_q      <= base_d;
            bad_q       <= bad_d;
            bit_cnt_q   <= bit_cnt_d;
            idx_q       <= idx_d;
            wdig_q      <= wdig_d;
            digits_q    <= digits_d;
            blank_q     <= blank_d;
            overflow_q  <= overflow_d;
            error_q     <= error_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign digits    = digits_q;
    assign blank     = blank_q;
    assign overflow  = overflow_q;
    assign error     = error_q;

endmodule

// File: tb/tb_radix_converter.sv
// Bench for radix_converter: table of directed vectors, random requests checked
// against an arithmetic reference model, plus backpressure and mid-run reset sequences.
module tb_radix_converter;

    localparam int BD = 16;
    localparam int ND = 5;
    localparam int DW = 4;
    localparam int LAT_OK  = ND * (BD + 1) + 1;
    localparam int LAT_BAD = 1;
    localparam int RW = ND * DW + ND + 3;   // {digits, blank, overflow, error, negative}

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [BD-1:0]     number;
    logic [DW:0]       base;
    logic              out_valid;
    logic              out_ready;
    logic [ND*DW-1:0]  digits;
    logic [ND-1:0]     blank;
    logic              overflow;
    logic              error;
    logic              negative;
    logic [RW-1:0]     result_vec;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] held;

    typedef struct {
        logic [BD-1:0] num;
        logic [DW:0]   b;
        logic [RW-1:0] exp;
    } vec_t;

    vec_t tbl[12];

    radix_converter #(.BIT_DEPTH(BD), .NUM_DIGITS(ND), .DIGIT_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .number(number), .base(base), .out_valid(out_valid), .out_ready(out_ready),
        .digits(digits), .blank(blank), .overflow(overflow), .error(error),
        .negative(negative)
    );

    assign result_vec = {digits, blank, overflow, error, negative};

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: repeated integer division by the base.
    function automatic logic [RW-1:0] ref_model(input logic [BD-1:0] n, input logic [DW:0] b);
        int v;
        int bi;
        logic [ND*DW-1:0] d;
        logic [ND-1:0] bl;
        logic ovf;
        logic neg;
        d = '0; bl = '0; neg = 1'b0;
        bi = int'(b);
        if (bi < 2 || bi > (1 << DW)) return {{(ND*DW){1'b0}}, {ND{1'b0}}, 1'b0, 1'b1, 1'b0};
        v = int'(n);
`ifdef RADIX_SIGNED_EN
        if (n[BD-1]) begin
            neg = 1'b1;
            v = (1 << BD) - int'(n);
        end
`endif
        for (int i = 0; i < ND; i++) begin
            d[i*DW +: DW] = DW'(v % bi);
            v = v / bi;
        end
        ovf = (v != 0);
        for (int i = 1; i < ND; i++) bl[i] = ((d >> (i * DW)) == '0);
        return {d, bl, ovf, 1'b0, neg};
    endfunction

    // Driver: issue one request, measure latency, check result, apply backpressure, release.
    task automatic run_req(input logic [BD-1:0] n, input logic [DW:0] b,
                           input logic [RW-1:0] exp, input int hold);
        int w;
        int lat;
        int exp_lat;
        logic [RW-1:0] e;
        exp_lat = (int'(b) < 2 || int'(b) > (1 << DW)) ? LAT_BAD : LAT_OK;
        exp_q.push_back(exp);
        number = n; base = b; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("held_during_run", 32'(result_vec), 32'(held));
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 300);
        chk("latency", 32'(lat), 32'(exp_lat));
        e = exp_q.pop_front();
        chk("result", 32'(result_vec), 32'(e));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            number = BD'($urandom);
            base = 5'd10;
            @(posedge clk); #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_stable", 32'(result_vec), 32'(e));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_ready", 32'(in_ready), 32'd1);
        chk("release_hold", 32'(result_vec), 32'(e));
        held = e;
    endtask

    initial begin
        // Directed table: {number, base, {digits, blank, ovf, err, neg}}.
        tbl[0]  = '{16'd1234,  5'd10, {20'h01234, 5'b10000, 3'b000}};
        tbl[1]  = '{16'h0005,  5'd2,  {20'h00101, 5'b11000, 3'b000}};
        tbl[2]  = '{16'h0020,  5'd2,  {20'h00000, 5'b11110, 3'b100}};
        tbl[3]  = '{16'd1234,  5'd1,  {20'h00000, 5'b00000, 3'b010}};
        tbl[4]  = '{16'd1234,  5'd17, {20'h00000, 5'b00000, 3'b010}};
        tbl[5]  = '{16'd1234,  5'd0,  {20'h00000, 5'b00000, 3'b010}};
        tbl[6]  = '{16'd0,     5'd10, {20'h00000, 5'b11110, 3'b000}};
        tbl[7]  = '{16'h8000,  5'd10, {20'h32768, 5'b00000, 3'b001}};
`ifdef RADIX_SIGNED_EN
        tbl[8]  = '{16'hBEEF,  5'd16, {20'h04111, 5'b10000, 3'b001}};
        tbl[9]  = '{16'hFFFF,  5'd10, {20'h00001, 5'b11110, 3'b001}};
        tbl[10] = '{16'hFFFF,  5'd3,  {20'h00001, 5'b11110, 3'b001}};
        tbl[11] = '{16'hFB2E,  5'd10, {20'h01234, 5'b10000, 3'b001}};
`else
        tbl[7].exp[0] = 1'b0;
        tbl[8]  = '{16'hBEEF,  5'd16, {20'h0BEEF, 5'b10000, 3'b000}};
        tbl[9]  = '{16'hFFFF,  5'd10, {20'h65535, 5'b00000, 3'b000}};
        tbl[10] = '{16'hFFFF,  5'd3,  {20'h20020, 5'b00000, 3'b100}};
        tbl[11] = '{16'hFB2E,  5'd10, {20'h64302, 5'b00000, 3'b000}};
`endif

        // Reset block.
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; number = '0; base = '0;
        held = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_outputs", 32'(result_vec), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vectors.
        for (int k = 0; k < 12; k++) run_req(tbl[k].num, tbl[k].b, tbl[k].exp, (k == 0) ? 10 : 0);

        // Random requests against the reference model, with random backpressure.
        for (int k = 0; k < 30; k++) begin
            logic [BD-1:0] n;
            logic [DW:0]   b;
            n = BD'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(2, 16));
            run_req(n, b, ref_model(n, b), $urandom_range(0, 3));
        end

        // Reset 40 cycles into a conversion aborts it.
        number = 16'd4321; base = 5'd10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_outputs", 32'(result_vec), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        held = '0;
        repeat (100) @(posedge clk);
        #1;
        chk("abort_no_result", 32'(out_valid), 32'd0);
        run_req(16'd99, 5'd10, {20'h00099, 5'b11100, 3'b000}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
